// File: rtl/rns_error_poly_stream_if.sv
// Error-BRAM read port and residue output stream of rns_error_poly_stream.
// master = the converter, slave = the BRAM/consumer side.
interface rns_error_poly_stream_if #(
    parameter int LOGN = 13,
    parameter int LOGQ = 54,
    parameter int LOGL = 2,
    parameter int EW   = 6
);
    logic            rd_en;
    logic [LOGN-1:0] rd_addr;
    logic [EW-1:0]   rd_data;
    logic            out_valid;
    logic            out_ready;
    logic [LOGQ-1:0] out_data;
    logic [LOGN-1:0] out_addr;
    logic [LOGL-1:0] out_mod;

    modport master (
        output rd_en, rd_addr,
        input  rd_data,
        output out_valid, out_data, out_addr, out_mod,
        input  out_ready
    );

    modport slave (
        input  rd_en, rd_addr,
        output rd_data,
        input  out_valid, out_data, out_addr, out_mod,
        output out_ready
    );
endinterface

// File: rtl/rns_error_poly_stream.sv
// Streams a sign-magnitude error polynomial as residues mod each RNS modulus, with credit-based skid FIFO.
// Optional sticky range flag `err` is built when RNS_ERR_CHECK_EN is defined.
module rns_error_poly_stream #(
    parameter int N           = 8192,
    parameter int LOGN        = 13,
    parameter int LOGQ        = 54,
    parameter int NUM_MODULI  = 4,
    parameter int LOGL        = 2,
    parameter int EW          = 6,
    parameter int BRAM_RD_LAT = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [NUM_MODULI*LOGQ-1:0] q_all,
    output logic                       busy,
    output logic                       done,
`ifdef RNS_ERR_CHECK_EN
    output logic                       err,
`endif
    rns_error_poly_stream_if.master    bus
);
    localparam int PTRW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNTW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

    typedef struct packed {
        logic [EW-1:0]   word;
        logic [LOGN-1:0] addr;
        logic [LOGL-1:0] mod;
    } entry_t;

    state_e                           state_q, state_d;
    logic [LOGN-1:0]                  addr_q, addr_d;
    logic [LOGL-1:0]                  mod_q, mod_d;
    logic [BRAM_RD_LAT-1:0]           pv_q, pv_d;
    logic [BRAM_RD_LAT-1:0][LOGN-1:0] pa_q, pa_d;
    logic [BRAM_RD_LAT-1:0][LOGL-1:0] pm_q, pm_d;
    logic [PTRW-1:0]                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]                  count_q, count_d;
    entry_t                           fifo_mem_q [FIFO_DEPTH];

    int              inflight;
    logic            rd_en, last_rd, push, pop, out_valid, range_bad;
    entry_t          head;
    logic [LOGQ-1:0] q_sel, mag, conv;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        inflight = 0;
        for (int k = 0; k < BRAM_RD_LAT; k++) inflight += int'(pv_q[k]);

        rd_en     = (state_q == S_RUN) && ((inflight + int'(count_q)) < FIFO_DEPTH);
        last_rd   = (addr_q == LOGN'(N - 1)) && (mod_q == LOGL'(NUM_MODULI - 1));
        push      = pv_q[BRAM_RD_LAT-1];
        out_valid = (count_q != '0);
        pop       = out_valid && bus.out_ready;

        pv_d[0] = rd_en;
        pa_d[0] = addr_q;
        pm_d[0] = mod_q;
        for (int k = 1; k < BRAM_RD_LAT; k++) begin
            pv_d[k] = pv_q[k-1];
            pa_d[k] = pa_q[k-1];
            pm_d[k] = pm_q[k-1];
        end

        addr_d = addr_q;
        mod_d  = mod_q;
        if (state_q == S_IDLE && start) begin
            addr_d = '0;
            mod_d  = '0;
        end else if (rd_en) begin
            addr_d = (addr_q == LOGN'(N - 1)) ? '0 : addr_q + 1'b1;
            if (addr_q == LOGN'(N - 1))
                mod_d = (mod_q == LOGL'(NUM_MODULI - 1)) ? '0 : mod_q + 1'b1;
        end

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = (wr_ptr_q == PTRW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = (rd_ptr_q == PTRW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // DRAIN looks at next-cycle occupancy so done follows the last pop directly.
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (rd_en && last_rd) state_d = S_DRAIN;
            S_DRAIN: if (count_d == '0 && pv_d == '0) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        head  = fifo_mem_q[rd_ptr_q];
        mag   = LOGQ'(head.word[EW-2:0]);
        q_sel = '0;
        for (int i = 0; i < NUM_MODULI; i++)
            if (head.mod == LOGL'(i)) q_sel = q_all[i*LOGQ +: LOGQ];
`ifdef RNS_ERR_CHECK_EN
        range_bad = (mag >= q_sel);
`else
        range_bad = 1'b0;
`endif
        // Negative zero maps to 0, never to q_i.
        if (range_bad)                 conv = '0;
        else if (!head.word[EW-1])     conv = mag;
        else if (mag == '0)            conv = '0;
        else                           conv = q_sel - mag;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            mod_q    <= '0;
            pv_q     <= '0;
            pa_q     <= '0;
            pm_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            mod_q    <= mod_d;
            pv_q     <= pv_d;
            pa_q     <= pa_d;
            pm_q     <= pm_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: FIFO storage has no reset; count_q gates every use of it, so flushing the pointers is enough.
    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wr_ptr_q] <= '{word: bus.rd_data, addr: pa_q[BRAM_RD_LAT-1], mod: pm_q[BRAM_RD_LAT-1]};
    end

`ifdef RNS_ERR_CHECK_EN
    logic err_q, err_d;
    always_comb err_d = err_q | (pop & range_bad);
    always_ff @(posedge clk) begin
        if (!rst) err_q <= 1'b0;
        else      err_q <= err_d;
    end
    assign err = err_q;
`endif

    assign busy          = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done          = (state_q == S_DONE);
    assign bus.rd_en     = rd_en;
    assign bus.rd_addr   = addr_q;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_valid ? conv : '0;
    assign bus.out_addr  = out_valid ? head.addr : '0;
    assign bus.out_mod   = out_valid ? head.mod : '0;
endmodule

// File: tb/tb_rns_error_poly_stream.sv
// Directed bench for rns_error_poly_stream: N=8, two moduli, LOGQ=54, 2-cycle BRAM model.
// Honours RNS_ERR_CHECK_EN when the design is built with it.
module tb_rns_error_poly_stream;
    localparam int N = 8, LOGN = 3, LOGQ = 54, NM = 2, LOGL = 1, EW = 6, LAT = 2, DEPTH = 4;

    typedef struct {
        logic [LOGQ-1:0] d;
        logic [LOGN-1:0] a;
        logic [LOGL-1:0] m;
    } obs_t;

    logic              clk, rst, start, busy, done;
    logic [NM*LOGQ-1:0] q_all;
`ifdef RNS_ERR_CHECK_EN
    logic              err;
`endif

    rns_error_poly_stream_if #(.LOGN(LOGN), .LOGQ(LOGQ), .LOGL(LOGL), .EW(EW)) bus ();

    rns_error_poly_stream #(
        .N(N), .LOGN(LOGN), .LOGQ(LOGQ), .NUM_MODULI(NM), .LOGL(LOGL),
        .EW(EW), .BRAM_RD_LAT(LAT), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .q_all (q_all),
        .busy  (busy),
        .done  (done),
`ifdef RNS_ERR_CHECK_EN
        .err   (err),
`endif
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [EW-1:0] bram_mem [N];
    logic [EW-1:0] s1, s2;
    always @(posedge clk) begin
        s1 <= bram_mem[bus.rd_addr];
        s2 <= s1;
    end
    assign bus.rd_data = s2;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    obs_t got_q[$];
    logic [LOGQ-1:0] exp_d [NM][N];
    int   rel, reads, pops, max_out, done_cnt, done_cyc, first_pop, last_pop;
    logic busy_c1, rden_c1, busy_at_done;
    logic [LOGN-1:0] rdaddr_c1;
    bit   mon_on = 0;

    always @(negedge clk) begin
        if (mon_on) begin
            if (bus.rd_en) reads++;
            if (bus.out_valid && bus.out_ready) begin
                got_q.push_back(obs_t'{bus.out_data, bus.out_addr, bus.out_mod});
                if (first_pop < 0) first_pop = rel;
                last_pop = rel;
                pops++;
            end
            if (reads - pops > max_out) max_out = reads - pops;
            if (rel == 1) begin
                busy_c1   = busy;
                rden_c1   = bus.rd_en;
                rdaddr_c1 = bus.rd_addr;
            end
            if (done) begin
                done_cnt++;
                done_cyc     = rel;
                busy_at_done = busy;
            end
        end
    end

    // rmode: 0 ready held high, 1 ready pattern 1,0,0,1, 2 ready low for 20 cycles then high
    task automatic do_run(input int rmode, input int extra_start, input int rst_at, input int budget);
        got_q.delete();
        reads = 0; pops = 0; max_out = 0; done_cnt = 0; done_cyc = -1;
        first_pop = -1; last_pop = -1; rel = -1;
        mon_on = 1;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk); #1;
            if (done_cnt > 0) break;
            rel   = k;
            start = (k == 0) || (k == extra_start);
            rst   = (k == rst_at) ? 1'b0 : 1'b1;
            case (rmode)
                1:       bus.out_ready = (k % 4 == 0) || (k % 4 == 3);
                2:       bus.out_ready = (k >= 20);
                default: bus.out_ready = 1'b1;
            endcase
            if (rmode == 2 && (k == 10 || k == 19)) begin
                @(negedge clk); #1;
                check($sformatf("stall_reads_c%0d", k), reads, 4);
                check($sformatf("stall_valid_c%0d", k), bus.out_valid, 1);
                check($sformatf("stall_rden_c%0d", k), bus.rd_en, 0);
                check($sformatf("stall_addr_c%0d", k), bus.out_addr, 0);
                check($sformatf("stall_mod_c%0d", k), bus.out_mod, 0);
                check($sformatf("stall_data_c%0d", k), bus.out_data, 3);
            end
        end
        start  = 1'b0;
        mon_on = 0;
    endtask

    task automatic verify_seq(input string name);
        int m, a;
        check({name, "_count"}, got_q.size(), NM * N);
        for (int i = 0; i < got_q.size() && i < NM * N; i++) begin
            m = i / N;
            a = i % N;
            check($sformatf("%s_data%0d", name, i), got_q[i].d, exp_d[m][a]);
            check($sformatf("%s_addr%0d", name, i), got_q[i].a, a);
            check($sformatf("%s_mod%0d", name, i), got_q[i].m, m);
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; bus.out_ready = 1'b0;
        q_all = {54'd97, 54'd17};
        bram_mem = '{6'd3, 6'd35, 6'd0, 6'd32, 6'd31, 6'd33, 6'd5, 6'd37};
        exp_d[0] = '{54'd3, 54'd14, 54'd0, 54'd0, 54'd31, 54'd16, 54'd5, 54'd12};
        exp_d[1] = '{54'd3, 54'd94, 54'd0, 54'd0, 54'd31, 54'd96, 54'd5, 54'd92};
`ifdef RNS_ERR_CHECK_EN
        exp_d[0][4] = 54'd0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rden", bus.rd_en, 0);
        check("rst_valid", bus.out_valid, 0);
        check("rst_data", bus.out_data, 0);

        // basic run
        do_run(0, -1, -1, 100);
        verify_seq("basic");
        check("basic_done_cnt", done_cnt, 1);
        check("basic_done_cyc", done_cyc, 20);
        check("basic_busy_at_done", busy_at_done, 0);
        check("basic_busy_c1", busy_c1, 1);
        check("basic_rden_c1", rden_c1, 1);
        check("basic_rdaddr_c1", rdaddr_c1, 0);
        check("basic_first_pop", first_pop, 4);
        check("basic_no_bubble", last_pop - first_pop, NM * N - 1);
        check("basic_reads", reads, NM * N);
`ifdef RNS_ERR_CHECK_EN
        check("basic_err", err, 1);
`endif

        // backpressure
        do_run(1, -1, -1, 200);
        verify_seq("bp");
        check("bp_done_cnt", done_cnt, 1);
        check("bp_credit_ok", max_out <= DEPTH, 1);

        // full stall, then release
        do_run(2, -1, -1, 200);
        verify_seq("stall");
        check("stall_done_cnt", done_cnt, 1);

        // start while busy
        do_run(0, 5, -1, 100);
        verify_seq("restart");
        check("restart_done_cnt", done_cnt, 1);
        check("restart_done_cyc", done_cyc, 20);

        // reset at cycle 7
        do_run(0, -1, 7, 8);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("mrst_busy", busy, 0);
        check("mrst_done", done, 0);
        check("mrst_rden", bus.rd_en, 0);
        check("mrst_rdaddr", bus.rd_addr, 0);
        check("mrst_valid", bus.out_valid, 0);
        check("mrst_data", bus.out_data, 0);
        check("mrst_addr", bus.out_addr, 0);
        check("mrst_mod", bus.out_mod, 0);
        check("mrst_no_done", done_cnt, 0);
`ifdef RNS_ERR_CHECK_EN
        check("mrst_err", err, 0);
`endif
        do_run(0, -1, -1, 100);
        verify_seq("fresh");
        check("fresh_done_cnt", done_cnt, 1);
        check("fresh_done_cyc", done_cyc, 20);

        // full-width modulus, input -31
        q_all = {54'h3F_FFFF_FFFF_FFDF, 54'h3F_FFFF_FFFF_FFDF};
        for (int i = 0; i < N; i++) begin
            bram_mem[i] = 6'd63;
            exp_d[0][i] = 54'h3F_FFFF_FFFF_FFC0;
            exp_d[1][i] = 54'h3F_FFFF_FFFF_FFC0;
        end
        do_run(0, -1, -1, 100);
        verify_seq("wide");
        check("wide_done_cnt", done_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
